// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, sizing helpers.
package seq_alu_pkg;

  // Op codes carried on ALUControl
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_MULHU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_REMU  = 4'b1011;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of the iteration counter: must hold 0 .. width-1
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  // True for the four iterative multiply/divide codes (10xx)
  function automatic logic is_muldiv_code(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle datapath: add/sub/and/or/slt/xor with carry and
// overflow. Any code outside that set yields Result 0 and both flags 0.
module alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;
  logic           add_ovf_s;
  logic           sub_ovf_s;
  logic           slt_s;

  // Extra top bit of each sum is the carry out; subtraction is A + ~B + 1
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Signed overflow: operands agree in sign (B inverted for sub) but result differs
  assign add_ovf_s = (a[WIDTH-1] == b[WIDTH-1])  && (sum_s[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf_s = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);

  // Signed less-than: sign of A-B corrected for overflow
  assign slt_s = diff_s[WIDTH-1] ^ sub_ovf_s;

  // Select result and flags by op code
  always_comb begin
    result   = {WIDTH{1'b0}};
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum_s[WIDTH-1:0];
        carry    = sum_s[WIDTH];
        overflow = add_ovf_s;
      end
      ALU_SUB: begin
        result   = diff_s[WIDTH-1:0];
        carry    = diff_s[WIDTH];
        overflow = sub_ovf_s;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_XOR: result = a ^ b;
      default: begin
        result   = {WIDTH{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops complete in one cycle, unsigned mul/mulhu/
// divu/remu iterate one bit per cycle. Result and flags are registered and held
// until the next done pulse.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         md_sel_r;     // low op bits: 00 mul, 01 mulhu, 10 divu, 11 remu
  logic [2*WIDTH-1:0] prod_r;       // {partial high, multiplier shifting out}
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;        // dividend shifting out, quotient shifting in

  logic [WIDTH-1:0]   comb_result_s;
  logic               comb_carry_s;
  logic               comb_ovf_s;
  logic               md_in_s;
  logic               accept_s;
  logic               last_step_s;

  logic [WIDTH-1:0]   mul_add_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_step_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_sub_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;

  logic               load_s;
  logic [WIDTH-1:0]   result_next_s;
  logic               carry_next_s;
  logic               ovf_next_s;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .a        (A),
    .b        (B),
    .op       (ALUControl),
    .result   (comb_result_s),
    .carry    (comb_carry_s),
    .overflow (comb_ovf_s)
  );

  // Multi-cycle codes only count as such when the iterative unit is built
  assign md_in_s     = (MULDIV_EN != 1'b0) && is_muldiv_code(ALUControl);
  assign accept_s    = (state_r == IDLE) && start;
  assign last_step_s = (state_r == CALC) && (cnt_r == CW'(WIDTH - 1));

  // Shift-add multiply step: add A into the high half when the multiplier LSB is set
  assign mul_add_s   = prod_r[0] ? a_r : {WIDTH{1'b0}};
  assign mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_add_s};
  assign prod_step_s = {mul_sum_s, prod_r[WIDTH-1:1]};

  // Restoring divide step: bring in next dividend bit, subtract B if it fits
  assign div_shift_s = {rem_r, quo_r[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, b_r});
  assign div_sub_s   = div_shift_s[WIDTH-1:0] - b_r;
  assign rem_step_s  = div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0];
  assign quo_step_s  = {quo_r[WIDTH-2:0], div_ge_s};

  // Next-state logic for IDLE -> (CALC) -> DONE -> IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (md_in_s) begin
            state_next_s = CALC;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Value loaded into Result/flags on entry to DONE
  always_comb begin
    load_s        = 1'b0;
    result_next_s = {WIDTH{1'b0}};
    carry_next_s  = 1'b0;
    ovf_next_s    = 1'b0;
    if (accept_s && !md_in_s) begin
      load_s        = 1'b1;
      result_next_s = comb_result_s;
      carry_next_s  = comb_carry_s;
      ovf_next_s    = comb_ovf_s;
    end else if (last_step_s) begin
      load_s = 1'b1;
      case (md_sel_r)
        2'b00:   result_next_s = prod_step_s[WIDTH-1:0];
        2'b01:   result_next_s = prod_step_s[2*WIDTH-1:WIDTH];
        2'b10:   result_next_s = quo_step_s;
        2'b11:   result_next_s = rem_step_s;
        default: result_next_s = {WIDTH{1'b0}};
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // State, handshake outputs and iteration counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == CALC);
      done    <= (state_next_s == DONE);
      if (accept_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == CALC) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Operand capture and iterative mul/div datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      md_sel_r <= 2'b00;
      prod_r   <= {(2*WIDTH){1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_r      <= A;
      b_r      <= B;
      md_sel_r <= ALUControl[1:0];
      prod_r   <= {{WIDTH{1'b0}}, B};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= A;
    end else if (state_r == CALC) begin
      if (md_sel_r[1] == 1'b0) begin
        prod_r <= prod_step_s;
      end else begin
        rem_r <= rem_step_s;
        quo_r <= quo_step_s;
      end
    end else begin
      prod_r <= prod_r;
    end
  end

  // Registered result and flags, updated only when an op completes
  always_ff @(posedge clk) begin
    if (!rst) begin
      Result   <= {WIDTH{1'b0}};
      Carry    <= 1'b0;
      OverFlow <= 1'b0;
      Zero     <= 1'b1;
      Negative <= 1'b0;
    end else if (load_s) begin
      Result   <= result_next_s;
      Carry    <= carry_next_s;
      OverFlow <= ovf_next_s;
      Zero     <= (result_next_s == {WIDTH{1'b0}});
      Negative <= result_next_s[WIDTH-1];
    end else begin
      Result <= Result;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed test-plan steps plus random ops
// compared against an arithmetic reference model, and an 8-bit no-muldiv build.
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [3:0]  ALUControl = 4'h0;
  logic        busy, done, Carry, OverFlow, Zero, Negative;
  logic [31:0] Result;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = 8'h0;
  logic [7:0]  b8 = 8'h0;
  logic [3:0]  op8 = 4'h0;
  logic        busy8, done8, carry8, ovf8, zero8, neg8;
  logic [7:0]  res8;

  int checks = 0;
  int errors = 0;

  logic [3:0]  op_pool [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0111,
                                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b1111};
  logic [31:0] specials [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

  seq_alu #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .ALUControl(ALUControl),
    .busy(busy), .done(done), .Result(Result), .Carry(Carry), .OverFlow(OverFlow),
    .Zero(Zero), .Negative(Negative)
  );

  seq_alu #(.WIDTH(8), .MULDIV_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .ALUControl(op8),
    .busy(busy8), .done(done8), .Result(res8), .Carry(carry8), .OverFlow(ovf8),
    .Zero(zero8), .Negative(neg8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour computed directly from the op definitions
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub, full;
    longint sa, sb, s;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e = '0;
    case (op)
      4'b0000: begin
        full = ua + ub;
        e.r = full[31:0];
        e.c = (full >= 64'h1_0000_0000);
        s = sa + sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: begin
        e.r = a - b;
        e.c = (ua >= ub);
        s = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0010: e.r = a & b;
      4'b0011: e.r = a | b;
      4'b0101: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0111: e.r = a ^ b;
      4'b1000: begin full = ua * ub; e.r = full[31:0];  end
      4'b1001: begin full = ua * ub; e.r = full[63:32]; end
      4'b1010: e.r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'b1011: e.r = (b == 32'd0) ? a : a % b;
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Issue one op, track latency/busy, check result, flags and the single done pulse.
  // With poke set, start is raised mid-operation and must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke);
    exp_t e;
    int   k;
    int   busy_cnt;
    int   extra_done;
    bit   got;
    bit   md;
    e  = model(op, a, b);
    md = (op[3:2] == 2'b10);
    @(negedge clk);
    start = 1'b1; A = a; B = b; ALUControl = op;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
    k = 0; busy_cnt = 0; got = 1'b0;
    while (!got && k <= 40) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (poke) start = (k == 5);
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, got ? 64'(k) : 64'd999, md ? 64'd32 : 64'd0);
    check({tag, " busy_cycles"}, 64'(busy_cnt), md ? 64'd32 : 64'd0);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, " result"}, {32'd0, Result}, {32'd0, e.r});
    check({tag, " flags_cvzn"}, {60'd0, Carry, OverFlow, Zero, Negative},
          {60'd0, e.c, e.v, e.z, e.n});
    @(posedge clk); #1;
    check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    if (poke) begin
      extra_done = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra_done++;
      end
      check({tag, " extra_done"}, 64'(extra_done), 64'd0);
      check({tag, " result_held"}, {32'd0, Result}, {32'd0, e.r});
    end
  endtask

  initial begin
    int  nd;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", {32'd0, Result}, 64'd0);
    check("reset flags_cvzn", {60'd0, Carry, OverFlow, Zero, Negative}, 64'b0010);
    rst = 1'b1;

    // Single-cycle ops
    run_op(4'b0000, 32'd15, 32'd10, "add 15+10", 1'b0);
    run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, "add ovf", 1'b0);
    run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, "add carry", 1'b0);
    run_op(4'b0001, 32'd50, 32'd50, "sub equal", 1'b0);
    run_op(4'b0001, 32'd10, 32'd50, "sub borrow", 1'b0);
    run_op(4'b0101, 32'hFFFF_FFFB, 32'd5, "slt neg", 1'b0);
    run_op(4'b0100, 32'd3, 32'd4, "illegal 0100", 1'b0);

    // Multi-cycle ops
    run_op(4'b1000, 32'h0001_0000, 32'h0003_0000, "mul", 1'b0);
    run_op(4'b1001, 32'h0001_0000, 32'h0003_0000, "mulhu", 1'b1);
    run_op(4'b1010, 32'd100, 32'd7, "divu", 1'b0);
    run_op(4'b1011, 32'd100, 32'd7, "remu", 1'b0);
    run_op(4'b1010, 32'd9, 32'd0, "divu by0", 1'b0);
    run_op(4'b1011, 32'd9, 32'd0, "remu by0", 1'b0);

    // Reset during CALC cycle 10 of a divide
    @(negedge clk);
    start = 1'b1; A = 32'd100; B = 32'd7; ALUControl = 4'b1010;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort result", {32'd0, Result}, 64'd0);
    check("abort zero", {63'd0, Zero}, 64'd1);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    check("abort no_done", 64'(nd), 64'd0);
    run_op(4'b0000, 32'd1, 32'd1, "add after abort", 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = op_pool[$urandom_range(0, 11)];
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      run_op(rop, ra, rb, $sformatf("rand%0d op%b", i, rop), 1'b0);
    end

    // 8-bit build without mul/div: 1000 and 1010 are illegal
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd3; op8 = 4'b1000;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("w8 illegal mul done", {63'd0, done8}, 64'd1);
    check("w8 illegal mul busy", {63'd0, busy8}, 64'd0);
    check("w8 illegal mul result", {56'd0, res8}, 64'd0);
    check("w8 illegal mul flags_cvzn", {60'd0, carry8, ovf8, zero8, neg8}, 64'b0010);
    @(posedge clk); #1;
    check("w8 done_pulse", {63'd0, done8}, 64'd0);

    @(negedge clk);
    start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; op8 = 4'b0000;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("w8 add done", {63'd0, done8}, 64'd1);
    check("w8 add result", {56'd0, res8}, 64'h80);
    check("w8 add flags_cvzn", {60'd0, carry8, ovf8, zero8, neg8}, 64'b0101);
    @(posedge clk); #1;

    @(negedge clk);
    start8 = 1'b1; a8 = 8'd40; b8 = 8'd6; op8 = 4'b1010;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("w8 illegal divu done", {63'd0, done8}, 64'd1);
    check("w8 illegal divu result", {56'd0, res8}, 64'd0);
    check("w8 illegal divu zero", {63'd0, zero8}, 64'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
